// File: rtl/bp_lce_sync_responder_pkg.sv
// Shared BedRock message types, configuration bus and header layouts for the LCE sync responder.
// Sizes mirror the default processor configuration used by this slice.
package bp_lce_sync_responder_pkg;

    localparam int num_cce_p      = 2;
    localparam int cce_id_width_p = 3;
    localparam int lce_id_width_p = 4;
    localparam int paddr_width_p  = 40;
    localparam int dword_width_gp = 64;

    typedef enum logic [3:0] {
        e_bedrock_cmd_sync      = 4'd0,
        e_bedrock_cmd_set_clear = 4'd1,
        e_bedrock_cmd_inv       = 4'd2,
        e_bedrock_cmd_st        = 4'd3,
        e_bedrock_cmd_data      = 4'd4
    } bp_bedrock_cmd_type_e;

    typedef enum logic [3:0] {
        e_bedrock_rsp_sync_ack = 4'd0,
        e_bedrock_rsp_inv_ack  = 4'd1,
        e_bedrock_rsp_coh_ack  = 4'd2,
        e_bedrock_rsp_wb       = 4'd3,
        e_bedrock_rsp_null_wb  = 4'd4
    } bp_bedrock_rsp_type_e;

    typedef enum logic [2:0] {
        e_bedrock_msg_size_1 = 3'd0,
        e_bedrock_msg_size_2 = 3'd1,
        e_bedrock_msg_size_4 = 3'd2,
        e_bedrock_msg_size_8 = 3'd3
    } bp_bedrock_msg_size_e;

    typedef enum logic [1:0] {
        e_lce_mode_uncached = 2'd0,
        e_lce_mode_normal   = 2'd1,
        e_lce_mode_nonspec  = 2'd2
    } bp_lce_mode_e;

    typedef struct packed {
        logic [lce_id_width_p-1:0] lce_id;
        bp_lce_mode_e              lce_mode;
    } bp_cfg_bus_s;

    typedef struct packed {
        logic [lce_id_width_p-1:0] dst_id;
        logic [cce_id_width_p-1:0] src_id;
    } bp_cmd_payload_s;

    typedef struct packed {
        bp_bedrock_cmd_type_e     msg_type;
        logic [paddr_width_p-1:0] addr;
        bp_bedrock_msg_size_e     size;
        bp_cmd_payload_s          payload;
    } bp_cmd_header_s;

    typedef struct packed {
        logic [cce_id_width_p-1:0] dst_id;
        logic [lce_id_width_p-1:0] src_id;
    } bp_rsp_payload_s;

    typedef struct packed {
        bp_bedrock_rsp_type_e     msg_type;
        logic [paddr_width_p-1:0] addr;
        bp_bedrock_msg_size_e     size;
        bp_rsp_payload_s          payload;
    } bp_rsp_header_s;

endpackage

// File: rtl/bp_lce_sync_responder_chk.sv
// Simulation-only contract checks on the command side of the sync responder.
module bp_lce_sync_responder_chk
    import bp_lce_sync_responder_pkg::*;
#(
    parameter int lce_data_width_p = dword_width_gp
) (
    input logic                        clk_i,
    input logic                        reset_n_i,
    input bp_cmd_header_s              cmd_header_i,
    input logic                        header_hs_i,
    input logic [lce_data_width_p-1:0] data_i,
    input logic                        data_hs_i,
    input logic [lce_id_width_p-1:0]   lce_id_i
);
    // The upstream demux only routes sync commands addressed to this LCE.
    a_sync_only: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        header_hs_i |-> (cmd_header_i.msg_type == e_bedrock_cmd_sync));

    a_addressed: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        header_hs_i |-> (!$isunknown(cmd_header_i) && (cmd_header_i.payload.dst_id == lce_id_i)));

    a_data_known: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        data_hs_i |-> !$isunknown(data_i));
endmodule

// File: rtl/bp_lce_sync_responder_synced.sv
// Set/clear bit vector with synchronous active-high reset; clear wins over a simultaneous set.
module bp_lce_sync_responder_synced #(
    parameter int width_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] set_i,
    input  logic [width_p-1:0] clear_i,
    output logic [width_p-1:0] data_o
);
    logic [width_p-1:0] data_q;

    // Accumulate set bits, then apply clears on top.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_q <= '0;
        end else begin
            data_q <= (data_q | set_i) & ~clear_i;
        end
    end

    assign data_o = data_q;
endmodule

// File: rtl/bp_lce_sync_responder.sv
// LCE-side endpoint of the CCE sync handshake: acks each sync and tracks which CCEs have synced.
module bp_lce_sync_responder
    import bp_lce_sync_responder_pkg::*;
#(
    parameter int lce_data_width_p = dword_width_gp
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  bp_cfg_bus_s                 cfg_bus_i,
    input  bp_cmd_header_s              lce_cmd_header_i,
    input  logic                        lce_cmd_header_v_i,
    output logic                        lce_cmd_header_ready_and_o,
    input  logic                        lce_cmd_has_data_i,
    input  logic [lce_data_width_p-1:0] lce_cmd_data_i,
    input  logic                        lce_cmd_data_v_i,
    output logic                        lce_cmd_data_ready_and_o,
    input  logic                        lce_cmd_last_i,
    output bp_rsp_header_s              lce_resp_header_o,
    output logic                        lce_resp_header_v_o,
    input  logic                        lce_resp_header_ready_and_i,
    output logic                        lce_resp_has_data_o,
    output logic [lce_data_width_p-1:0] lce_resp_data_o,
    output logic                        lce_resp_data_v_o,
    output logic                        lce_resp_last_o,
    output logic                        sync_done_o,
    output logic                        proto_error_o
);
    typedef enum logic [1:0] {
        e_ready      = 2'd0,
        e_drain_data = 2'd1,
        e_send_ack   = 2'd2
    } state_e;

    localparam logic [cce_id_width_p-1:0] num_cce_lp = cce_id_width_p'(num_cce_p);

    state_e                    state_q;
    logic                      resp_v_q;
    logic                      proto_error_q;
    logic [cce_id_width_p-1:0] cce_id_q;
    logic [paddr_width_p-1:0]  addr_q;
    logic [num_cce_p-1:0]      synced_q;
    logic [num_cce_p-1:0]      set_s;
    logic [num_cce_p-1:0]      clear_s;
    logic                      header_hs_s;
    logic                      data_hs_s;
    logic                      ack_hs_s;
    bp_rsp_header_s            resp_hdr_s;

    assign lce_cmd_header_ready_and_o = reset_n_i & (state_q == e_ready);
    assign lce_cmd_data_ready_and_o   = reset_n_i & (state_q == e_drain_data);
    assign header_hs_s = lce_cmd_header_v_i & lce_cmd_header_ready_and_o;
    assign data_hs_s   = lce_cmd_data_v_i & lce_cmd_data_ready_and_o;
    assign ack_hs_s    = resp_v_q & lce_resp_header_ready_and_i;

    // Handshake FSM with registered response valid and sticky protocol error.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q       <= e_ready;
            resp_v_q      <= 1'b0;
            proto_error_q <= 1'b0;
        end else begin
            case (state_q)
                e_ready: begin
                    if (header_hs_s) begin
                        if (lce_cmd_has_data_i) begin
                            state_q <= e_drain_data;
                        end else begin
                            state_q  <= e_send_ack;
                            resp_v_q <= 1'b1;
                        end
                        if (lce_cmd_has_data_i || (lce_cmd_header_i.payload.src_id >= num_cce_lp)) begin
                            proto_error_q <= 1'b1;
                        end
                    end
                end
                e_drain_data: begin
                    if (data_hs_s && lce_cmd_last_i) begin
                        state_q  <= e_send_ack;
                        resp_v_q <= 1'b1;
                    end
                end
                e_send_ack: begin
                    if (ack_hs_s) begin
                        state_q  <= e_ready;
                        resp_v_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= e_ready;
                    resp_v_q <= 1'b0;
                end
            endcase
        end
    end

    // Capture register: issuing CCE and address of the accepted sync.
    always_ff @(posedge clk_i) begin
        if (header_hs_s) begin
            cce_id_q <= lce_cmd_header_i.payload.src_id;
            addr_q   <= lce_cmd_header_i.addr;
        end
    end

    // Response header is built only from captured state, so it stays stable under backpressure.
    always_comb begin
        resp_hdr_s                = '0;
        resp_hdr_s.msg_type       = e_bedrock_rsp_sync_ack;
        resp_hdr_s.addr           = addr_q;
        resp_hdr_s.size           = e_bedrock_msg_size_1;
        resp_hdr_s.payload.src_id = cfg_bus_i.lce_id;
        resp_hdr_s.payload.dst_id = cce_id_q;
    end

    assign set_s   = (ack_hs_s && (cce_id_q < num_cce_lp))
                   ? ({{(num_cce_p-1){1'b0}}, 1'b1} << cce_id_q) : '0;
    assign clear_s = {num_cce_p{cfg_bus_i.lce_mode == e_lce_mode_uncached}};

    bp_lce_sync_responder_synced #(
        .width_p (num_cce_p)
    ) u_synced (
        .clk_i   (clk_i),
        .reset_i (~reset_n_i),
        .set_i   (set_s),
        .clear_i (clear_s),
        .data_o  (synced_q)
    );

    bp_lce_sync_responder_chk #(
        .lce_data_width_p (lce_data_width_p)
    ) u_chk (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .cmd_header_i (lce_cmd_header_i),
        .header_hs_i  (header_hs_s),
        .data_i       (lce_cmd_data_i),
        .data_hs_i    (data_hs_s),
        .lce_id_i     (cfg_bus_i.lce_id)
    );

    assign lce_resp_header_o   = resp_hdr_s;
    assign lce_resp_header_v_o = resp_v_q;
    assign lce_resp_has_data_o = 1'b0;
    assign lce_resp_data_o     = '0;
    assign lce_resp_data_v_o   = 1'b0;
    assign lce_resp_last_o     = 1'b0;
    assign sync_done_o         = &synced_q;
    assign proto_error_o       = proto_error_q;
endmodule

// File: tb/tb_bp_lce_sync_responder.sv
// Directed self-checking bench for the LCE sync responder (2 CCEs, lce_id 3).
module tb_bp_lce_sync_responder;
    import bp_lce_sync_responder_pkg::*;

    logic                 clk;
    logic                 reset_n;
    bp_cfg_bus_s          cfg_bus;
    bp_cmd_header_s       cmd_hdr;
    logic                 cmd_hdr_v;
    logic                 cmd_hdr_ready;
    logic                 cmd_has_data;
    logic [63:0]          cmd_data;
    logic                 cmd_data_v;
    logic                 cmd_data_ready;
    logic                 cmd_last;
    bp_rsp_header_s       resp_hdr;
    logic                 resp_hdr_v;
    logic                 resp_hdr_ready;
    logic                 resp_has_data;
    logic [63:0]          resp_data;
    logic                 resp_data_v;
    logic                 resp_last;
    logic                 sync_done;
    logic                 proto_error;

    int n_checks = 0;
    int n_errors = 0;

    bp_lce_sync_responder #(.lce_data_width_p(64)) dut (
        .clk_i                       (clk),
        .reset_n_i                   (reset_n),
        .cfg_bus_i                   (cfg_bus),
        .lce_cmd_header_i            (cmd_hdr),
        .lce_cmd_header_v_i          (cmd_hdr_v),
        .lce_cmd_header_ready_and_o  (cmd_hdr_ready),
        .lce_cmd_has_data_i          (cmd_has_data),
        .lce_cmd_data_i              (cmd_data),
        .lce_cmd_data_v_i            (cmd_data_v),
        .lce_cmd_data_ready_and_o    (cmd_data_ready),
        .lce_cmd_last_i              (cmd_last),
        .lce_resp_header_o           (resp_hdr),
        .lce_resp_header_v_o         (resp_hdr_v),
        .lce_resp_header_ready_and_i (resp_hdr_ready),
        .lce_resp_has_data_o         (resp_has_data),
        .lce_resp_data_o             (resp_data),
        .lce_resp_data_v_o           (resp_data_v),
        .lce_resp_last_o             (resp_last),
        .sync_done_o                 (sync_done),
        .proto_error_o               (proto_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_hdr(input logic [2:0] cce, input logic [39:0] addr, input logic has_data);
        cmd_hdr                = '0;
        cmd_hdr.msg_type       = e_bedrock_cmd_sync;
        cmd_hdr.addr           = addr;
        cmd_hdr.size           = e_bedrock_msg_size_8;
        cmd_hdr.payload.dst_id = 4'd3;
        cmd_hdr.payload.src_id = cce;
        cmd_has_data           = has_data;
        cmd_hdr_v              = 1'b1;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        cmd_hdr_v      = 1'b0;
        cmd_has_data   = 1'b0;
        cmd_data_v     = 1'b0;
        cmd_last       = 1'b0;
        cmd_data       = 64'd0;
        resp_hdr_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        check_eq("rst_cmd_ready", 64'(cmd_hdr_ready), 64'd0);
        check_eq("rst_resp_v", 64'(resp_hdr_v), 64'd0);
        check_eq("rst_done", 64'(sync_done), 64'd0);
        check_eq("rst_proto", 64'(proto_error), 64'd0);
        reset_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check_eq("post_rst_ready", 64'(cmd_hdr_ready), 64'd1);
    endtask

    // One header-only sync with an immediately accepted ack; starts and ends on a negedge in e_ready.
    task automatic do_sync(input logic [2:0] cce, input logic [39:0] addr, input logic exp_done);
        drive_hdr(cce, addr, 1'b0);
        check_eq("hdr_ready", 64'(cmd_hdr_ready), 64'd1);
        @(posedge clk); @(negedge clk);
        cmd_hdr_v = 1'b0;
        check_eq("ack_v", 64'(resp_hdr_v), 64'd1);
        check_eq("ack_type", 64'(resp_hdr.msg_type), 64'(e_bedrock_rsp_sync_ack));
        check_eq("ack_dst", 64'(resp_hdr.payload.dst_id), 64'(cce));
        check_eq("ack_src", 64'(resp_hdr.payload.src_id), 64'd3);
        check_eq("ack_addr", 64'(resp_hdr.addr), 64'(addr));
        check_eq("ack_size", 64'(resp_hdr.size), 64'(e_bedrock_msg_size_1));
        check_eq("busy_ready", 64'(cmd_hdr_ready), 64'd0);
        @(posedge clk); @(negedge clk);
        check_eq("ack_done_v", 64'(resp_hdr_v), 64'd0);
        check_eq("sync_done", 64'(sync_done), 64'(exp_done));
    endtask

    initial begin
        cfg_bus.lce_id   = 4'd3;
        cfg_bus.lce_mode = e_lce_mode_normal;
        cmd_hdr          = '0;

        // Basic pair of syncs.
        do_reset();
        do_sync(3'd0, 40'h00_0000_1000, 1'b0);
        do_sync(3'd1, 40'h00_0000_2040, 1'b1);
        check_eq("t1_proto", 64'(proto_error), 64'd0);
        check_eq("tied_has_data", 64'(resp_has_data), 64'd0);
        check_eq("tied_data_v", 64'(resp_data_v | resp_last), 64'd0);
        check_eq("tied_data", resp_data, 64'd0);

        // Backpressure on the response for 5 cycles.
        do_reset();
        resp_hdr_ready = 1'b0;
        drive_hdr(3'd0, 40'hAB_CDEF_0123, 1'b0);
        @(posedge clk); @(negedge clk);
        cmd_hdr_v = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_v", 64'(resp_hdr_v), 64'd1);
            check_eq("stall_addr", 64'(resp_hdr.addr), 64'hAB_CDEF_0123);
            check_eq("stall_dst", 64'(resp_hdr.payload.dst_id), 64'd0);
            check_eq("stall_cmd_ready", 64'(cmd_hdr_ready), 64'd0);
            @(posedge clk); @(negedge clk);
        end
        resp_hdr_ready = 1'b1;
        check_eq("stall_v6", 64'(resp_hdr_v), 64'd1);
        @(posedge clk); @(negedge clk);
        check_eq("stall_released", 64'(resp_hdr_v), 64'd0);
        check_eq("stall_ready", 64'(cmd_hdr_ready), 64'd1);
        check_eq("stall_done", 64'(sync_done), 64'd0);

        // Duplicate sync from cce 0.
        do_reset();
        do_sync(3'd0, 40'h10, 1'b0);
        do_sync(3'd0, 40'h20, 1'b0);
        do_sync(3'd1, 40'h30, 1'b1);

        // Uncached mode clears and holds synced state.
        cfg_bus.lce_mode = e_lce_mode_uncached;
        @(posedge clk); @(negedge clk);
        check_eq("unc_done_drop", 64'(sync_done), 64'd0);
        do_sync(3'd0, 40'h40, 1'b0);
        do_sync(3'd1, 40'h50, 1'b0);
        cfg_bus.lce_mode = e_lce_mode_normal;
        @(posedge clk); @(negedge clk);
        check_eq("unc_stays_clear", 64'(sync_done), 64'd0);

        // Sync carrying two data beats.
        do_reset();
        drive_hdr(3'd0, 40'h88, 1'b1);
        @(posedge clk); @(negedge clk);
        cmd_hdr_v    = 1'b0;
        cmd_has_data = 1'b0;
        check_eq("drain_ready", 64'(cmd_data_ready), 64'd1);
        check_eq("drain_no_ack", 64'(resp_hdr_v), 64'd0);
        check_eq("drain_proto", 64'(proto_error), 64'd1);
        cmd_data_v = 1'b1; cmd_data = 64'hDEAD_BEEF_0000_0001; cmd_last = 1'b0;
        @(posedge clk); @(negedge clk);
        check_eq("beat1_ready", 64'(cmd_data_ready), 64'd1);
        check_eq("beat1_no_ack", 64'(resp_hdr_v), 64'd0);
        cmd_data = 64'hDEAD_BEEF_0000_0002; cmd_last = 1'b1;
        @(posedge clk); @(negedge clk);
        cmd_data_v = 1'b0; cmd_last = 1'b0;
        check_eq("drain_ack_v", 64'(resp_hdr_v), 64'd1);
        check_eq("drain_done_ready", 64'(cmd_data_ready), 64'd0);
        check_eq("drain_ack_dst", 64'(resp_hdr.payload.dst_id), 64'd0);
        @(posedge clk); @(negedge clk);
        check_eq("drain_ack_hs", 64'(resp_hdr_v), 64'd0);
        check_eq("proto_sticky", 64'(proto_error), 64'd1);

        // CCE id outside the configured range.
        do_reset();
        do_sync(3'd5, 40'h99, 1'b0);
        check_eq("oor_proto", 64'(proto_error), 64'd1);
        do_sync(3'd0, 40'h9A, 1'b0);
        do_sync(3'd1, 40'h9B, 1'b1);

        // Reset while an ack is pending.
        do_reset();
        do_sync(3'd0, 40'h100, 1'b0);
        resp_hdr_ready = 1'b0;
        drive_hdr(3'd1, 40'h200, 1'b0);
        @(posedge clk); @(negedge clk);
        cmd_hdr_v = 1'b0;
        check_eq("mid_ack_v", 64'(resp_hdr_v), 64'd1);
        reset_n = 1'b0;
        @(posedge clk); @(negedge clk);
        check_eq("mid_rst_v", 64'(resp_hdr_v), 64'd0);
        check_eq("mid_rst_ready", 64'(cmd_hdr_ready), 64'd0);
        reset_n        = 1'b1;
        resp_hdr_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        do_sync(3'd1, 40'h300, 1'b0);
        do_sync(3'd0, 40'h400, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
